spi_reg_slave: RTL and testbench

Parametrised SPI mode-0 register slave: the next-generation host interface of the TFT panel controller, in the same position (host SPI pins to the internal control register file). It keeps the existing 8-bit-address / 32-bit-data MSB-first write frame and adds:
- generic widths and register count;
- read-back over MISO;
- read-only status registers;
- frame-error detection with a saturating error counter.

Everything runs in the system clock domain, with oversampled SPI pins.

---
 rtl/spi_reg_pkg.sv | 15 +
 rtl/spi_sync_edge.sv | 29 ++
 rtl/spi_reg_slave.sv | 201 ++++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared FSM type and default widths for the SPI register slave.
package spi_reg_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned ERR_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with registered edge pulses.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {2{RST_VAL}};
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin};
            rise   <= sync_q[0] & ~sync_q[1];
            fall   <= ~sync_q[0] & sync_q[1];
        end
    end

    assign level = sync_q[1];

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave: address/data frames from host pins into a register
// file, with read-back, read-only status slots and frame-error accounting.
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int unsigned         ADDR_W   = DEF_ADDR_W,
    parameter int unsigned         DATA_W   = DEF_DATA_W,
    parameter int unsigned         NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         spi_sclk,
    input  logic                         spi_mosi,
    input  logic                         spi_cs_n,
    output logic                         spi_miso,
    input  logic [NUM_REGS*DATA_W-1:0]   sts_i,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic                         wr_stb,
    output logic                         rd_stb,
    output logic [ADDR_W-2:0]            acc_idx,
    output logic                         frame_err,
    output logic [ERR_CNT_W-1:0]         err_cnt,
    output logic                         busy
);

    localparam int unsigned IDX_W = ADDR_W - 1;
    localparam int unsigned SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CNT_W = $clog2(SH_W + 1);

    state_e state_q, state_d;

    logic              sclk_rise, sclk_fall, sclk_lvl_unused;
    logic              cs_rise, cs_fall, cs_lvl;
    logic [1:0]        mosi_sync_q;
    logic              mosi_s;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [SH_W-2:0]   shift_q;
    logic [SH_W-1:0]   shift_next_c;
    logic [IDX_W-1:0]  idx_q, dec_idx_c;
    logic              rd_q, overrun_q, err_seen_q;
    logic [DATA_W-1:0] miso_sr_q, rd_word_c;
    logic              decode_c, commit_c, overrun_set_c, frame_err_c;
    logic              in_range_c, ro_c, wr_ok_c, err_inc_c, shifting_c;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (spi_sclk),
        .level (sclk_lvl_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // Reset value 0 so a cs_n still low at reset release never looks like a frame start.
    spi_sync_edge #(.RST_VAL(1'b0)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (spi_cs_n),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_sync_q <= 2'b00;
        end else begin
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
        end
    end

    assign mosi_s = mosi_sync_q[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        decode_c      = 1'b0;
        commit_c      = 1'b0;
        overrun_set_c = 1'b0;
        frame_err_c   = 1'b0;
        unique case (state_q)
            IDLE: if (cs_fall) state_d = ADDR;
            ADDR: if (sclk_rise && bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                decode_c = 1'b1;
                state_d  = DATA;
            end
            DATA: if (sclk_rise && bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                commit_c = 1'b1;
                state_d  = DONE;
            end
            DONE: if (sclk_rise) overrun_set_c = 1'b1;
            default: state_d = IDLE;
        endcase
        // cs_n release ends any frame; short or overrun frames are flagged.
        if (state_q != IDLE && cs_rise) begin
            state_d       = IDLE;
            decode_c      = 1'b0;
            commit_c      = 1'b0;
            overrun_set_c = 1'b0;
            frame_err_c   = (state_q != DONE) || overrun_q;
        end
    end

    always_comb begin
        shift_next_c = {shift_q, mosi_s};
        dec_idx_c    = (state_q == ADDR) ? shift_next_c[IDX_W-1:0] : idx_q;
        in_range_c   = ({1'b0, dec_idx_c} < ADDR_W'(NUM_REGS));
        ro_c         = 1'b0;
        rd_word_c    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (dec_idx_c == IDX_W'(i)) begin
                ro_c      = RO_MASK[i];
                rd_word_c = RO_MASK[i] ? sts_i[i*DATA_W +: DATA_W] : reg_q[i*DATA_W +: DATA_W];
            end
        end
    end

    assign shifting_c = sclk_rise && (state_q == ADDR || state_q == DATA);
    assign wr_ok_c    = commit_c & ~rd_q & in_range_c & ~ro_c;
    assign err_inc_c  = ~err_seen_q &
                        ((decode_c & shift_next_c[ADDR_W-1] & ~in_range_c) |
                         (commit_c & ~rd_q & ~(in_range_c & ~ro_c)) |
                         frame_err_c);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            idx_q      <= '0;
            rd_q       <= 1'b0;
            overrun_q  <= 1'b0;
            err_seen_q <= 1'b0;
            miso_sr_q  <= '0;
            reg_q      <= '0;
            spi_miso   <= 1'b0;
            wr_stb     <= 1'b0;
            rd_stb     <= 1'b0;
            acc_idx    <= '0;
            frame_err  <= 1'b0;
            err_cnt    <= '0;
            busy       <= 1'b0;
        end else begin
            wr_stb    <= wr_ok_c;
            rd_stb    <= decode_c & shift_next_c[ADDR_W-1];
            frame_err <= frame_err_c;
            busy      <= (state_d != IDLE);

            if (state_q == IDLE && cs_fall) begin
                bit_cnt_q  <= '0;
                overrun_q  <= 1'b0;
                err_seen_q <= 1'b0;
            end else if (decode_c) begin
                bit_cnt_q <= '0;
            end else if (shifting_c) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end

            if (shifting_c) shift_q <= shift_next_c[SH_W-2:0];

            if (decode_c) begin
                idx_q <= dec_idx_c;
                rd_q  <= shift_next_c[ADDR_W-1];
                if (shift_next_c[ADDR_W-1]) begin
                    miso_sr_q <= rd_word_c;
                    acc_idx   <= dec_idx_c;
                end
            end

            if (wr_ok_c) begin
                acc_idx <= idx_q;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (idx_q == IDX_W'(i)) reg_q[i*DATA_W +: DATA_W] <= shift_next_c[DATA_W-1:0];
                end
            end

            if (overrun_set_c) overrun_q <= 1'b1;

            if (err_inc_c) begin
                err_seen_q <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
            end

            // MISO only carries data during a read's data phase; held low otherwise.
            if (state_q != DATA || !rd_q || cs_lvl) begin
                spi_miso <= 1'b0;
            end else if (sclk_fall) begin
                spi_miso  <= miso_sr_q[DATA_W-1];
                miso_sr_q <= {miso_sr_q[DATA_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: directed and random SPI frames against a
// register-file model that applies the frame rules directly.
module tb_spi_reg_slave;

    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 32;
    localparam int unsigned NR   = 16;
    localparam logic [NR-1:0] RO = 16'h0008;
    localparam int HALF = 5;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              spi_sclk = 1'b0;
    logic              spi_mosi = 1'b0;
    logic              spi_cs_n = 1'b1;
    logic              spi_miso;
    logic [NR*DW-1:0]  sts_i    = '0;
    logic [NR*DW-1:0]  reg_q;
    logic              wr_stb, rd_stb, frame_err, busy;
    logic [AW-2:0]     acc_idx;
    logic [7:0]        err_cnt;

    always #5 clk = ~clk;

    spi_reg_slave #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .RO_MASK  (RO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .spi_miso  (spi_miso),
        .sts_i     (sts_i),
        .reg_q     (reg_q),
        .wr_stb    (wr_stb),
        .rd_stb    (rd_stb),
        .acc_idx   (acc_idx),
        .frame_err (frame_err),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int wr_cnt = 0, rd_cnt = 0, fe_cnt = 0;
    int last_wr_cyc = 0, last_rd_cyc = 0, last_fe_cyc = 0;
    logic [AW-2:0] last_wr_idx = '0, last_rd_idx = '0;
    int addr_rise_cyc = 0, data_rise_cyc = 0, cs_rise_cyc = 0;
    logic [DW-1:0] rx;
    logic          stray;
    logic [DW-1:0] m_regs [NR];
    int            m_err = 0;
    int            w0, r0, f0, nb;
    logic [7:0]    ra;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_stb)    begin wr_cnt++; last_wr_cyc = cyc; last_wr_idx = acc_idx; end
        if (rd_stb)    begin rd_cnt++; last_rd_cyc = cyc; last_rd_idx = acc_idx; end
        if (frame_err) begin fe_cnt++; last_fe_cyc = cyc; end
    end

    task automatic check(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_regs[i];
        return f;
    endfunction

    task automatic clock_bits(input logic [63:0] word, input int nbits);
        rx    = '0;
        stray = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            spi_mosi = word[63-b];
            repeat (HALF) @(negedge clk);
            if (b >= int'(AW) && b < int'(AW + DW)) rx = {rx[DW-2:0], spi_miso};
            else if (spi_miso !== 1'b0) stray = 1'b1;
            spi_sclk = 1'b1;
            if (b == int'(AW) - 1)      addr_rise_cyc = cyc;
            if (b == int'(AW + DW) - 1) data_rise_cyc = cyc;
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [63:0] word, input int nbits, input string tag);
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        check($sformatf("%s_busy_hi", tag), busy, 1);
        clock_bits(word, nbits);
        repeat (HALF) @(negedge clk);
        spi_cs_n    = 1'b1;
        cs_rise_cyc = cyc;
        repeat (8) @(negedge clk);
    endtask

    // Expected outcome of one frame, straight from the frame rules.
    task automatic run_frame(input logic [7:0] addr, input logic [31:0] data, input int nbits, input string tag);
        logic [63:0] word;
        logic [6:0]  idx;
        logic [3:0]  i4;
        bit rd, ok_idx, ro, full, over, bad, exp_wr, exp_rd, exp_fe;
        logic [DW-1:0] exp_rx;
        int wc, rc, fc;
        word   = {addr, data, 24'($urandom)};
        rd     = addr[7];
        idx    = addr[6:0];
        i4     = idx[3:0];
        ok_idx = (int'(idx) < int'(NR));
        ro     = ok_idx && RO[i4];
        full   = nbits >= int'(AW + DW);
        over   = nbits > int'(AW + DW);
        exp_rd = rd && nbits >= int'(AW);
        exp_wr = full && !rd && ok_idx && !ro;
        bad    = (exp_rd && !ok_idx) || (full && !rd && !(ok_idx && !ro));
        exp_fe = !full || over;
        exp_rx = '0;
        if (rd && ok_idx) exp_rx = ro ? sts_i[int'(i4)*DW +: DW] : m_regs[i4];
        wc = wr_cnt; rc = rd_cnt; fc = fe_cnt;
        spi_frame(word, nbits, tag);
        if (exp_wr) m_regs[i4] = data;
        if ((bad || exp_fe) && m_err < 255) m_err++;
        check($sformatf("%s_wr_stb", tag), wr_cnt - wc, exp_wr);
        check($sformatf("%s_rd_stb", tag), rd_cnt - rc, exp_rd);
        check($sformatf("%s_frame_err", tag), fe_cnt - fc, exp_fe);
        check($sformatf("%s_err_cnt", tag), err_cnt, m_err);
        check($sformatf("%s_reg_q", tag), reg_q, model_flat());
        check($sformatf("%s_busy_lo", tag), busy, 0);
        check($sformatf("%s_miso_idle", tag), stray, 0);
        if (exp_wr) begin
            check($sformatf("%s_wr_idx", tag), last_wr_idx, idx);
            check($sformatf("%s_wr_lat", tag), last_wr_cyc - data_rise_cyc, 3);
        end
        if (exp_rd) begin
            check($sformatf("%s_rd_idx", tag), last_rd_idx, idx);
            check($sformatf("%s_rd_lat", tag), last_rd_cyc - addr_rise_cyc, 3);
        end
        if (exp_fe) check($sformatf("%s_fe_lat", tag), last_fe_cyc - cs_rise_cyc, 3);
        if (full)   check($sformatf("%s_miso_data", tag), rx, rd ? exp_rx : '0);
    endtask

    initial begin
        for (int i = 0; i < int'(NR); i++) begin
            sts_i[i*DW +: DW] = $urandom;
            m_regs[i] = '0;
        end
        sts_i[3*DW +: DW] = 32'hCAFE_0001;

        repeat (4) @(negedge clk);
        check("rst_reg_q", reg_q, '0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_miso", spi_miso, 0);
        check("rst_strobes", {wr_stb, rd_stb, frame_err}, 0);
        check("rst_acc_idx", acc_idx, 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        run_frame(8'h02, 32'h0000_0005, 40, "wr02");
        run_frame(8'h05, 32'hA5A5_1234, 40, "wr05");
        run_frame(8'h85, 32'h0000_0000, 40, "rd85");
        run_frame(8'h03, 32'hFFFF_FFFF, 40, "wr_ro03");
        run_frame(8'h83, 32'h1234_5678, 40, "rd_ro83");
        run_frame(8'h20, 32'h0BAD_0BAD, 40, "wr_oor20");
        run_frame(8'hA0, 32'hFFFF_FFFF, 40, "rd_oorA0");
        run_frame(8'h06, 32'h6666_6666, 20, "abort20");
        run_frame(8'h07, 32'h1357_9BDF, 41, "overrun41");
        run_frame(8'hA1, 32'h0, 12, "rd_oor_abort");

        for (int k = 0; k < 30; k++) begin
            ra = {1'($urandom), 7'($urandom_range(0, 19))};
            nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 45)) : 40;
            run_frame(ra, $urandom, nb, $sformatf("rnd%0d", k));
        end

        // Reset in the middle of a frame with cs_n held low throughout.
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        clock_bits({8'h01, 32'h1234_5678, 24'h0}, 12);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_reg_q", reg_q, '0);
        check("midrst_err_cnt", err_cnt, 0);
        check("midrst_busy", busy, 0);
        check("midrst_miso", spi_miso, 0);
        check("midrst_strobes", {wr_stb, rd_stb, frame_err}, 0);
        check("midrst_acc_idx", acc_idx, 0);
        rst_n = 1'b1;
        for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
        m_err = 0;
        w0 = wr_cnt; r0 = rd_cnt; f0 = fe_cnt;
        clock_bits({8'h01, 32'hDEAD_BEEF, 24'h0}, 40);
        check("postrst_no_wr", wr_cnt - w0, 0);
        check("postrst_no_rd", rd_cnt - r0, 0);
        check("postrst_busy", busy, 0);
        check("postrst_reg_q", reg_q, '0);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check("postrst_no_fe", fe_cnt - f0, 0);
        check("postrst_err_cnt", err_cnt, 0);
        run_frame(8'h01, 32'h0BAD_F00D, 40, "postrst_wr");

        for (int k = 0; k < 300; k++) run_frame(8'h00, 32'h0, 0, $sformatf("sat%0d", k));
        check("err_cnt_saturated", err_cnt, 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
